// File: rtl/mux_2to1.sv
// mux_2to1: 2-to-1 data selector with registered copy and select-toggle tracking
module mux_2to1 #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic             Selector,
    output logic [WIDTH-1:0] OutMux,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] OutMux_q,
    output logic             Sel_q,
    output logic             Sel_toggle,
    output logic [CNT_W-1:0] Toggle_count
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             sel_q, sel_d;
    logic             tog_q, tog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_chg;

    assign OutMux       = Selector ? In_B : In_A;
    assign sel_chg      = Selector != sel_q;
    assign OutMux_q     = out_q;
    assign Sel_q        = sel_q;
    assign Sel_toggle   = tog_q;
    assign Toggle_count = cnt_q;

    // Next state: capture on en; toggle pulse clears when disabled; counter saturates
    always_comb begin
        out_d = en ? OutMux : out_q;
        sel_d = en ? Selector : sel_q;
        tog_d = en && sel_chg;
        cnt_d = (en && sel_chg && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    // State registers with synchronous active-low reset taking priority over en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            sel_q <= 1'b0;
            tog_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
            tog_q <= tog_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: randomized and directed self-checking bench against a behavioural model
module tb_mux_2to1;
    logic       clk = 1'b0;
    logic       rst_n, en, sel;
    logic [4:0] a, b;
    logic [4:0] out, out_q, out2, out_q2;
    logic       sel_q, tog, sel_q2, tog2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int checks = 0;
    int failures = 0;

    int m_out, m_sel, m_tog, m_cnt, m_cnt2;

    always #5 clk = ~clk;

    mux_2to1 u_dut (
        .In_A(a), .In_B(b), .Selector(sel), .OutMux(out),
        .clk(clk), .rst_n(rst_n), .en(en),
        .OutMux_q(out_q), .Sel_q(sel_q), .Sel_toggle(tog), .Toggle_count(cnt)
    );

    mux_2to1 #(.CNT_W(2)) u_dut2 (
        .In_A(a), .In_B(b), .Selector(sel), .OutMux(out2),
        .clk(clk), .rst_n(rst_n), .en(en),
        .OutMux_q(out_q2), .Sel_q(sel_q2), .Sel_toggle(tog2), .Toggle_count(cnt2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check the mux, clock, advance model, check registers
    task automatic step(input int ia, input int ib, input int is, input int ie, input int ir);
        int changed;
        @(negedge clk);
        a = 5'(ia); b = 5'(ib); sel = is[0]; en = ie[0]; rst_n = ir[0];
        #1;
        check("outmux", int'(out), is ? ib : ia);
        check("outmux_w2", int'(out2), is ? ib : ia);
        @(posedge clk);
        if (!ir) begin
            m_out = 0; m_sel = 0; m_tog = 0; m_cnt = 0; m_cnt2 = 0;
        end else if (ie) begin
            changed = (is != m_sel);
            m_tog = changed;
            if (changed) begin
                m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
            end
            m_out = is ? ib : ia;
            m_sel = is;
        end else begin
            m_tog = 0;
        end
        #1;
        check("outmux_q", int'(out_q), m_out);
        check("sel_q", int'(sel_q), m_sel);
        check("sel_toggle", int'(tog), m_tog);
        check("toggle_count", int'(cnt), m_cnt);
        check("outmux_q_w2", int'(out_q2), m_out);
        check("sel_toggle_w2", int'(tog2), m_tog);
        check("toggle_count_w2", int'(cnt2), m_cnt2);
    endtask

    initial begin
        m_out = 0; m_sel = 0; m_tog = 0; m_cnt = 0; m_cnt2 = 0;
        a = 0; b = 0; sel = 0; en = 1; rst_n = 0;
        // reset held two edges with Selector=1, then first enabled edge counts a toggle
        repeat (2) step(5'h0F, 5'h0A, 1, 1, 0);
        check("rst_out_q", int'(out_q), 0);
        check("rst_count", int'(cnt), 0);
        step(5'h0F, 5'h0A, 1, 1, 1);
        check("release_out_q", int'(out_q), 5'h0A);
        check("release_toggle", int'(tog), 1);
        check("release_count", int'(cnt), 1);
        // fresh reset, then selector 0-1-0-1 each held 100 ns
        step(5'h0F, 5'h0A, 0, 1, 0);
        for (int s = 0; s < 4; s++)
            repeat (10) step(5'h0F, 5'h0A, s % 2, 1, 1);
        check("plan_count3", int'(cnt), 3);
        // en=0 with selector toggling every cycle
        for (int i = 0; i < 5; i++) step(5'h0F, 5'h0A, i % 2, 0, 1);
        check("hold_count", int'(cnt), 3);
        // toggle every enabled cycle: narrow counter saturates
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(i, 31 - i, (i + 1) % 2, 1, 1);
        check("sat_count_w2", int'(cnt2), 3);
        check("sat_toggle_w2", int'(tog2), 1);
        // mid-sequence reset at count 2, then restart
        step(0, 0, 0, 1, 0);
        step(1, 2, 1, 1, 1);
        step(1, 2, 0, 1, 1);
        check("pre_mid_count", int'(cnt), 2);
        step(3, 4, 1, 1, 0);
        check("mid_rst_count", int'(cnt), 0);
        step(3, 4, 1, 1, 1);
        check("restart_count", int'(cnt), 1);
        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1),
                 ($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 40) != 0) ? 1 : 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
